// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq
//
// Power-switch sequencer for a gated supply domain. It drives NSEG switch or
// fillcap segments in thermometer order, one segment every STEP_CYC clocks.
// This limits inrush current. After the last segment is on, it waits one more
// STEP_CYC interval for the rail to settle and then raises PWR_ACK.
// Power-down walks the segments back off in reverse order.
//
// Ports:
//   CLK      in     rising-edge clock
//   RN       in     asynchronous active-low reset
//   VDD/VSS  inout  supply pins, no functional logic
//   PWR_REQ  in     1 = domain on requested, 0 = off requested (synchronous)
//   SW_EN    out    segment enables, thermometer code, bit 0 first on
//   PWR_ACK  out    domain fully on and settled
//   BUSY     out    ramp or settle in progress
//
// All outputs are registered.
// SW_EN moves by at most one bit per clock, so it never glitches.
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq #(
    parameter int NSEG     = 4,
    parameter int STEP_CYC = 8
) (
    input  logic            CLK,
    input  logic            RN,
    inout  wire             VDD,
    inout  wire             VSS,
    input  logic            PWR_REQ,
    output logic [NSEG-1:0] SW_EN,
    output logic            PWR_ACK,
    output logic            BUSY
);

    localparam int LW = $clog2(NSEG + 1);
    // STEP_CYC is at most 255, so an 8-bit counter always holds STEP_CYC-1.
    localparam int CW = 8;

    localparam logic [LW-1:0] LVL_FULL   = LW'(NSEG);
    localparam logic [LW-1:0] LVL_ONE    = LW'(1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(STEP_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_UP,
        ST_SETTLE,
        ST_ON,
        ST_DOWN
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NSEG-1:0] sw_en_q, therm_d;
    logic            ack_q;
    logic            busy_q;
    logic            cnt_expired;

    // The supply pins carry no logic.
    // They are referenced here only so that they are not left dangling.
    logic unused_pg;
    assign unused_pg = VDD ^ VSS;

    assign cnt_expired = (cnt_q == '0);

    // Next-state logic.
    // A reversal of PWR_REQ always takes priority over a pending step.
    // A reversal never moves the level. It only restarts the interval timer.
    // As a result, the first step in the new direction comes a full STEP_CYC
    // after the reversal.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_OFF: begin
                if (PWR_REQ) begin
                    level_d = LVL_ONE;
                    cnt_d   = CNT_RELOAD;
                    // A single-segment bank is full after the first step.
                    state_d = (LVL_ONE == LVL_FULL) ? ST_SETTLE : ST_UP;
                end
            end

            ST_UP: begin
                if (!PWR_REQ) begin
                    state_d = ST_DOWN;
                    cnt_d   = CNT_RELOAD;
                end else if (cnt_expired) begin
                    cnt_d = CNT_RELOAD;
                    if (level_q < LVL_FULL) begin
                        level_d = level_q + LVL_ONE;
                        // Settling starts on the edge that turns on the
                        // last segment.
                        if ((level_q + LVL_ONE) == LVL_FULL) begin
                            state_d = ST_SETTLE;
                        end
                    end else begin
                        // Reached only when UP is re-entered at full level
                        // after a reversal from DOWN.
                        state_d = ST_SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_SETTLE: begin
                if (!PWR_REQ) begin
                    state_d = ST_DOWN;
                    cnt_d   = CNT_RELOAD;
                end else if (cnt_expired) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_ON: begin
                if (!PWR_REQ) begin
                    level_d = LVL_FULL - LVL_ONE;
                    if (LVL_FULL == LVL_ONE) begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_DOWN;
                        cnt_d   = CNT_RELOAD;
                    end
                end
            end

            ST_DOWN: begin
                if (PWR_REQ) begin
                    state_d = ST_UP;
                    cnt_d   = CNT_RELOAD;
                end else if (cnt_expired) begin
                    if (level_q <= LVL_ONE) begin
                        level_d = '0;
                        state_d = ST_OFF;
                        cnt_d   = '0;
                    end else begin
                        level_d = level_q - LVL_ONE;
                        cnt_d   = CNT_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_OFF;
                level_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Thermometer decode of the next level.
    // It feeds the SW_EN register, so the pins see a clean registered code.
    genvar gi;
    generate
        for (gi = 0; gi < NSEG; gi++) begin : g_therm
            localparam logic [LW-1:0] SEG_IDX = LW'(gi);
            assign therm_d[gi] = (level_d > SEG_IDX);
        end
    endgenerate

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_OFF;
            level_q <= '0;
            cnt_q   <= '0;
            sw_en_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            sw_en_q <= therm_d;
            ack_q   <= (state_d == ST_ON);
            busy_q  <= (state_d == ST_UP) || (state_d == ST_SETTLE) ||
                       (state_d == ST_DOWN);
        end
    end

    assign SW_EN   = sw_en_q;
    assign PWR_ACK = ack_q;
    assign BUSY    = busy_q;

endmodule
